// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants, FSM encoding and writeback packet for the multiply/divide sequencer.
// Also consumed by the bypass and decode logic.
package multdiv_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 5;
    localparam int unsigned REG_W = 5;

    localparam logic [OPC_W-1:0] OPC_ALU  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_JAL  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SETX = 5'b10101;

    localparam logic [OPC_W-1:0] ALUOP_MUL = 5'b00110;
    localparam logic [OPC_W-1:0] ALUOP_DIV = 5'b00111;

    localparam logic [REG_W-1:0] REG_RSTATUS = 5'd30;
    localparam logic [REG_W-1:0] REG_RTA     = 5'd31;

    localparam logic [XLEN-1:0] STATUS_MUL_EXC = 32'd4;
    localparam logic [XLEN-1:0] STATUS_DIV_EXC = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] wr_reg;
        logic [XLEN-1:0]  wr_data;
    } md_wb_pkt_t;

endpackage

// File: rtl/multdiv_decode.sv
// Combinational mul/div detector for a D/X instruction word; reusable by hazard detection.
module multdiv_decode
    import multdiv_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]  insn,
    output logic             is_mul,
    output logic             is_div,
    output logic [REG_W-1:0] rd
);

    logic is_alu;
    logic unused_insn;

    assign is_alu = (insn[31:27] == OPC_ALU);
    assign is_mul = is_alu && (insn[6:2] == ALUOP_MUL);
    assign is_div = is_alu && (insn[6:2] == ALUOP_DIV);
    assign rd     = insn[26:22];

    assign unused_insn = ^{insn[21:7], insn[1:0]};

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/stall/writeback sequencer for the multi-cycle multiply/divide unit.
// Define MULTDIV_TIMEOUT_EN to add a BUSY watchdog that forces an exception after TIMEOUT cycles.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CW      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  dx_insn,
    input  logic             flush,
    input  logic             md_ready,
    input  logic             md_exception,
    input  logic [XLEN-1:0]  md_result,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             stall,
    output logic             md_valid,
    output logic             md_wr_en,
    output logic [REG_W-1:0] md_wr_reg,
    output logic [XLEN-1:0]  md_wr_data
);

    md_state_e        state_q, state_d;
    logic             op_div_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  data_q;
    logic             exc_q;

    logic             is_mul, is_div;
    logic [REG_W-1:0] dec_rd;
    logic             issue_c, cap_c, cap_exc_c, timeout_c;
    md_wb_pkt_t       pkt_c;

    multdiv_decode u_decode (
        .insn   (dx_insn),
        .is_mul (is_mul),
        .is_div (is_div),
        .rd     (dec_rd)
    );

`ifdef MULTDIV_TIMEOUT_EN
    logic [CW-1:0] cnt_q;

    // Watchdog: cleared at issue, counts every BUSY cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (issue_c) begin
            cnt_q <= '0;
        end else if (state_q == ST_BUSY) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout_c = (state_q == ST_BUSY) && (cnt_q == CW'(TIMEOUT - 1));
`else
    logic unused_cfg;

    assign timeout_c  = 1'b0;
    assign unused_cfg = (CW == 0) || (TIMEOUT == 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_div_q <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue_c) begin
                op_div_q <= is_div;
                rd_q     <= dec_rd;
            end
            if (cap_c) begin
                data_q <= md_ready ? md_result : '0;
                exc_q  <= cap_exc_c;
            end
        end
    end

    // Next state and outputs; everything is forced low while reset is asserted.
    always_comb begin
        state_d   = state_q;
        issue_c   = 1'b0;
        cap_c     = 1'b0;
        cap_exc_c = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        stall     = 1'b0;
        pkt_c     = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if ((is_mul || is_div) && !flush) begin
                        issue_c   = 1'b1;
                        ctrl_mult = is_mul;
                        ctrl_div  = is_div;
                        stall     = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    stall = 1'b1;
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else if (md_ready || timeout_c) begin
                        cap_c     = 1'b1;
                        cap_exc_c = md_ready ? md_exception : 1'b1;
                        state_d   = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    if (!flush) begin
                        pkt_c.valid = 1'b1;
                        if (exc_q) begin
                            // Exception writes a status code to r30, same as setx.
                            pkt_c.wr_en   = 1'b1;
                            pkt_c.wr_reg  = REG_RSTATUS;
                            pkt_c.wr_data = op_div_q ? STATUS_DIV_EXC : STATUS_MUL_EXC;
                        end else begin
                            pkt_c.wr_en   = (rd_q != '0);
                            pkt_c.wr_reg  = rd_q;
                            pkt_c.wr_data = data_q;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign md_valid   = pkt_c.valid;
    assign md_wr_en   = pkt_c.wr_en;
    assign md_wr_reg  = pkt_c.wr_reg;
    assign md_wr_data = pkt_c.wr_data;

endmodule
